rsp_s1_prep_mul_ctrl: RTL
=========================

RSP_S1_PREP_MUL_CTRL -- requirements
Module: rsp_s1_prep_mul_ctrl

Interface
REQ-001 The block SHALL have parameter SAMPLE_WIDTH, default 32, the sample width (complex {imag,real} or 2x16 real).
REQ-002 The block SHALL have parameter TWIDDLE_WIDTH, default 48, the weight width ({d,c}).
REQ-003 The block SHALL have parameter CNT_W, default 16, the frame-length counter width.
REQ-004 The block SHALL have parameter DRAIN_TO, default 16, the drain watchdog limit in cycles.
REQ-005 The block SHALL have the following ports, one per line:
 clk  in  1  clock; one clock domain.
 rst_n  in  1  asynchronous, active-low reset.
 i_start  in  1  one-cycle frame start.
 i_cfg_mode  in  1  1 = real/bypass, 0 = complex multiply; sampled on accepted i_start.
 i_cfg_len  in  CNT_W  samples in the frame; sampled on accepted i_start.
 s_x_data  in  SAMPLE_WIDTH  input sample.
 s_x_w  in  TWIDDLE_WIDTH  weight paired with the sample.
 s_x_valid  in  1  sample/weight valid.
 s_x_ready  out  1  controller accepts the sample.
 o_mul_x0_data  out  SAMPLE_WIDTH  to multiplier i_x0_data.
 o_mul_w  out  TWIDDLE_WIDTH  to multiplier i_w.
 o_mul_x0_valid  out  1  to multiplier i_x0_valid.
 o_mul_switch  out  1  to multiplier i_switch.
 i_mul_y0  in  SAMPLE_WIDTH  multiplier result.
 i_mul_y0_valid  in  1  multiplier result valid.
 m_y_data  out  SAMPLE_WIDTH  frame output.
 m_y_valid  out  1  output valid; no backpressure.
 m_y_last  out  1  marks the last sample of the frame.
 o_busy  out  1  high whenever state != IDLE.
 o_done  out  1  one-cycle end-of-frame pulse.
 o_err  out  1  sticky error flag.

Function
REQ-006 The FSM SHALL have exactly four states: IDLE, RUN, DRAIN, DONE.
REQ-007 IDLE: i_start SHALL latch mode and len, clear both counters, and clear o_err; the FSM SHALL go to RUN if len>0, else to DONE.
REQ-008 i_start SHALL be ignored in any state other than IDLE.
REQ-009 s_x_ready SHALL be 1 only in RUN, and only while issued_cnt < len.
REQ-010 Each accepted sample (s_x_valid & s_x_ready) SHALL be registered onto o_mul_x0_data/o_mul_w with o_mul_x0_valid=1 one cycle later, and SHALL increment issued_cnt.
REQ-011 Without an accepted sample, o_mul_x0_valid SHALL be 0 and o_mul_x0_data/o_mul_w SHALL hold their last values.
REQ-012 RUN SHALL go to DRAIN on the cycle issued_cnt reaches len.
REQ-013 o_mul_switch SHALL equal the latched mode from the cycle after i_start until the cycle after DONE, and SHALL change only in IDLE; mode never changes while samples are in flight.
REQ-014 Each i_mul_y0_valid SHALL be registered onto m_y_data/m_y_valid one cycle later and SHALL increment recv_cnt.
REQ-015 m_y_last SHALL be 1 with the result whose recv_cnt becomes len.
REQ-016 Total latency, s_x handshake to m_y_valid, SHALL be 2 + multiplier latency (8 complex, 5 real).
REQ-017 DRAIN SHALL go to DONE when recv_cnt == len.
REQ-018 DRAIN watchdog: DRAIN_TO consecutive cycles without i_mul_y0_valid SHALL set o_err and force DONE.
REQ-019 DONE SHALL assert o_done for exactly 1 cycle, then the FSM SHALL go to IDLE.
REQ-020 i_mul_y0_valid in IDLE or DONE, or with recv_cnt == len, SHALL set o_err, and that result SHALL be dropped (no m_y_valid).
REQ-021 A result in the same cycle as the last issue SHALL be counted normally.
REQ-022 Counters SHALL be CNT_W bits wide and SHALL never wrap: issue stops at len, and excess results are handled as in REQ-020.

Reset
REQ-023 While rst_n=0, the block SHALL be in state IDLE.
REQ-024 While rst_n=0, all outputs SHALL be 0: s_x_ready, o_mul_*, m_y_*, o_busy, o_done, o_err (data buses included).
REQ-025 While rst_n=0, both counters and the latched mode/len SHALL be 0.
REQ-026 Reset mid-frame SHALL abandon the frame immediately, with no o_done.
REQ-027 After reset, results still in flight in the multiplier SHALL be dropped and SHALL set o_err per REQ-020.

Verification
REQ-028 Bench: complex, len=4, s_x_valid constant -> 4 back-to-back o_mul_x0_valid, m_y_valid 8 cycles after each accept, m_y_last on the 4th, o_done 1 cycle after, o_switch=0 throughout.
REQ-029 Bench: real, len=3 with s_x_valid gaps -> m_y_data equals inputs, latency 5, o_mul_switch=1 from start through DONE.
REQ-030 Bench: len=0 -> o_done 2 cycles after i_start, no s_x_ready, no m_y_valid.
REQ-031 Bench: i_start during RUN -> ignored, len unchanged; spurious i_mul_y0_valid in IDLE -> o_err=1, no m_y_valid, cleared on next i_start.
REQ-032 Bench: complex len=4, model drops the last result -> DRAIN watchdog after 16 idle cycles, o_err=1, o_done=1.
REQ-033 Bench: rst_n low mid-RUN (issued_cnt=2) -> all outputs 0 asynchronously, FSM in IDLE, no o_done.

Source files
------------

// File: rtl/rsp_s1_prep_mul_ctrl.sv
// Frame controller in front of a complex/real multiplier: issues len samples,
// collects len results, flags stray results and drain timeouts on a sticky error.
module rsp_s1_prep_mul_ctrl #(
  parameter int SAMPLE_WIDTH  = 32,
  parameter int TWIDDLE_WIDTH = 48,
  parameter int CNT_W         = 16,
  parameter int DRAIN_TO      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_start,
  input  logic                     i_cfg_mode,
  input  logic [CNT_W-1:0]         i_cfg_len,
  input  logic [SAMPLE_WIDTH-1:0]  s_x_data,
  input  logic [TWIDDLE_WIDTH-1:0] s_x_w,
  input  logic                     s_x_valid,
  output logic                     s_x_ready,
  output logic [SAMPLE_WIDTH-1:0]  o_mul_x0_data,
  output logic [TWIDDLE_WIDTH-1:0] o_mul_w,
  output logic                     o_mul_x0_valid,
  output logic                     o_mul_switch,
  input  logic [SAMPLE_WIDTH-1:0]  i_mul_y0,
  input  logic                     i_mul_y0_valid,
  output logic [SAMPLE_WIDTH-1:0]  m_y_data,
  output logic                     m_y_valid,
  output logic                     m_y_last,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int WD_W = $clog2(DRAIN_TO + 1);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(DRAIN_TO - 1);
  localparam logic [WD_W-1:0]  WD_ONE  = WD_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             mode_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] issued_cnt;
  logic [CNT_W-1:0] recv_cnt;
  logic [WD_W-1:0]  wd_cnt;

  logic start_acc;
  logic x_acc;
  logic last_issue;
  logic y_window;
  logic y_ok;
  logic y_bad;
  logic last_recv;
  logic wd_expire;

  // Input handshake: a sample transfers on any cycle where s_x_valid and
  // s_x_ready are both high; valid may toggle freely, ready never waits on it.
  // The multiplier side and the m_y side carry no backpressure.
  assign s_x_ready  = (state == RUN) && (issued_cnt < len_q);
  assign x_acc      = s_x_valid && s_x_ready;
  assign last_issue = x_acc && ((issued_cnt + CNT_ONE) == len_q);
  assign start_acc  = (state == IDLE) && i_start;

  // A result is only legitimate while a frame is open and still owes results.
  assign y_window  = ((state == RUN) || (state == DRAIN)) && (recv_cnt != len_q);
  assign y_ok      = i_mul_y0_valid && y_window;
  assign y_bad     = i_mul_y0_valid && !y_window;
  assign last_recv = y_ok && ((recv_cnt + CNT_ONE) == len_q);
  assign wd_expire = (state == DRAIN) && !i_mul_y0_valid && (wd_cnt == WD_LAST);

  assign o_busy       = (state != IDLE);
  assign o_mul_switch = mode_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = (i_cfg_len != '0) ? RUN : DONE;
      RUN:     if (last_issue) state_nxt = DRAIN;
      DRAIN:   if (last_recv || wd_expire) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mode_q     <= 1'b0;
      len_q      <= '0;
      issued_cnt <= '0;
      recv_cnt   <= '0;
      wd_cnt     <= '0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      state  <= state_nxt;
      o_done <= (state == DONE);
      if (start_acc) begin
        mode_q     <= i_cfg_mode;
        len_q      <= i_cfg_len;
        issued_cnt <= '0;
        recv_cnt   <= '0;
      end else begin
        if (x_acc) issued_cnt <= issued_cnt + CNT_ONE;
        if (y_ok)  recv_cnt   <= recv_cnt + CNT_ONE;
      end
      // Watchdog counts consecutive result-free cycles, only while draining.
      if ((state != DRAIN) || i_mul_y0_valid) wd_cnt <= '0;
      else                                    wd_cnt <= wd_cnt + WD_ONE;
      if (y_bad || wd_expire) o_err <= 1'b1;
      else if (start_acc)     o_err <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_mul_x0_data  <= '0;
      o_mul_w        <= '0;
      o_mul_x0_valid <= 1'b0;
      m_y_data       <= '0;
      m_y_valid      <= 1'b0;
      m_y_last       <= 1'b0;
    end else begin
      o_mul_x0_valid <= x_acc;
      if (x_acc) begin
        o_mul_x0_data <= s_x_data;
        o_mul_w       <= s_x_w;
      end
      m_y_valid <= y_ok;
      m_y_last  <= last_recv;
      if (y_ok) m_y_data <= i_mul_y0;
    end
  end

endmodule
